// File: rtl/phy_tx.sv
// phy_tx: serializes four byte lanes (lane 0 first, MSB first) onto one line,
// preceded by four COM training frames. Optional byte counter: PHY_TX_STAT_EN.
module phy_tx (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  input  logic        val_in0,
  input  logic        val_in1,
  input  logic        val_in2,
  input  logic        val_in3,
  output logic        rd_frame,
  output logic        salida_tx
`ifdef PHY_TX_STAT_EN
  ,
  output logic [15:0] bytes_sent
`endif
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FRAME_W = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned TRAIN_W = 2;
  localparam int unsigned STAT_W  = 16;
  localparam int unsigned VCNT_W  = 3;

  localparam logic [BYTE_W-1:0]  COM        = 8'hBC;
  localparam logic [BYTE_W-1:0]  IDLE       = 8'h7C;
  localparam logic [CNT_W-1:0]   CNT_LAST   = 5'd31;
  localparam logic [CNT_W-1:0]   CNT_PRE    = 5'd30;
  localparam logic [TRAIN_W-1:0] TRAIN_LAST = 2'd3;

  typedef enum logic {ST_TRAIN, ST_DATA} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TRAIN_W-1:0]   train_cnt_q, train_cnt_d;
  logic [FRAME_W-1:0]   hold_q, hold_d;
  logic                 salida_q, salida_d;
  logic                 rd_frame_q, rd_frame_d;
  logic [FRAME_W-1:0]   data_frame;
  logic                 next_is_data;
  logic                 data_load;
`ifdef PHY_TX_STAT_EN
  logic [STAT_W-1:0]    bytes_q, bytes_d;
  logic [VCNT_W-1:0]    valid_cnt;
`endif

  // Lane 0 occupies the top byte so bit index 31-cnt walks lanes 0..3, MSB first.
  always_comb begin
    data_frame = {val_in0 ? in0 : IDLE,
                  val_in1 ? in1 : IDLE,
                  val_in2 ? in2 : IDLE,
                  val_in3 ? in3 : IDLE};
  end

  // Next-state and output logic; reload happens on the edge closing cnt==31.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    train_cnt_d  = train_cnt_q;
    hold_d       = hold_q;
    salida_d     = hold_q[~cnt_q];
    rd_frame_d   = 1'b0;
    data_load    = 1'b0;
    next_is_data = (state_q == ST_DATA) || (train_cnt_q == TRAIN_LAST);

    if (cnt_q == CNT_PRE) begin
      rd_frame_d = next_is_data;
    end

    if (cnt_q == CNT_LAST) begin
      case (state_q)
        ST_TRAIN: begin
          if (train_cnt_q == TRAIN_LAST) begin
            hold_d    = data_frame;
            state_d   = ST_DATA;
            data_load = 1'b1;
          end else begin
            hold_d      = {4{COM}};
            train_cnt_d = train_cnt_q + TRAIN_W'(1);
          end
        end
        ST_DATA: begin
          hold_d    = data_frame;
          data_load = 1'b1;
        end
        default: begin
          state_d = ST_TRAIN;
        end
      endcase
    end
  end

`ifdef PHY_TX_STAT_EN
  // Counts valid lanes accepted on each data reload, wrapping at 2^16.
  always_comb begin
    valid_cnt = VCNT_W'(val_in0) + VCNT_W'(val_in1) + VCNT_W'(val_in2) + VCNT_W'(val_in3);
    bytes_d   = bytes_q;
    if (data_load) begin
      bytes_d = bytes_q + STAT_W'(valid_cnt);
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bytes_q <= '0;
    end else begin
      bytes_q <= bytes_d;
    end
  end

  assign bytes_sent = bytes_q;
`endif

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_TRAIN;
      cnt_q       <= '0;
      train_cnt_q <= '0;
      hold_q      <= {4{COM}};
      salida_q    <= 1'b0;
      rd_frame_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      train_cnt_q <= train_cnt_d;
      hold_q      <= hold_d;
      salida_q    <= salida_d;
      rd_frame_q  <= rd_frame_d;
    end
  end

  assign salida_tx = salida_q;
  assign rd_frame  = rd_frame_q;

endmodule

// File: tb/tb_phy_tx.sv
// Bench for phy_tx: random lane traffic against a frame-level model of the line,
// plus literal frame checks for training, directed data and reset recovery.
module tb_phy_tx;

  logic        clk_32f;
  logic        reset_L;
  logic [7:0]  in0, in1, in2, in3;
  logic        val_in0, val_in1, val_in2, val_in3;
  logic        rd_frame;
  logic        salida_tx;
`ifdef PHY_TX_STAT_EN
  logic [15:0] bytes_sent;
`endif

  phy_tx dut (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .val_in0   (val_in0),
    .val_in1   (val_in1),
    .val_in2   (val_in2),
    .val_in3   (val_in3),
    .rd_frame  (rd_frame),
    .salida_tx (salida_tx)
`ifdef PHY_TX_STAT_EN
    ,
    .bytes_sent(bytes_sent)
`endif
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int          total = 0;
  int          bad   = 0;
  int          run   = 0;
  int          n     = 0;
  logic [31:0] cur_frame;
  logic [31:0] nxt_frame;
  logic [31:0] line_sr;
  int          exp_bytes = 0;
  int          pend_bytes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s run=%0d edge=%0d got=%h expected=%h", name, run, n, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input logic v, input logic [7:0] d);
    return v ? d : 8'h7C;
  endfunction

  // Model: edge n after release carries bit (n-1)%32 of frame (n-1)/32;
  // frames 0..3 are COM, later frames are the inputs seen just before edge 32f.
  always @(negedge clk_32f) begin
    if (!reset_L) begin
      n = 0;
      exp_bytes = 0;
      chk("reset_salida", 32'(salida_tx), 32'd0);
      chk("reset_rd_frame", 32'(rd_frame), 32'd0);
`ifdef PHY_TX_STAT_EN
      chk("reset_bytes", 32'(bytes_sent), 32'd0);
`endif
    end else begin
      int f, p;
      n++;
      f = (n - 1) / 32;
      p = (n - 1) % 32;
      if (p == 0) cur_frame = (f < 4) ? {4{8'hBC}} : nxt_frame;
      if (n % 32 == 0 && n >= 128) exp_bytes = (exp_bytes + pend_bytes) % 65536;
      chk("salida", 32'(salida_tx), 32'(cur_frame[31-p]));
      chk("rd_frame", 32'(rd_frame), 32'((n % 32 == 31) && (n >= 127)));
`ifdef PHY_TX_STAT_EN
      chk("bytes_sent", 32'(bytes_sent), 32'(exp_bytes));
`endif
      line_sr = {line_sr[30:0], salida_tx};
      if (n % 32 == 0) begin
        if (n <= 128) chk("lit_train", line_sr, 32'hBCBCBCBC);
        if (run == 1 && n == 160) chk("lit_0123", line_sr, 32'h01234567);
        if (run == 1 && n == 192) chk("lit_1010", line_sr, 32'hAA7CCC7C);
        if (run == 1 && n == 224) chk("lit_idle", line_sr, 32'h7C7C7C7C);
      end
      if ((n + 1) % 32 == 0 && (n + 1) >= 128) begin
        nxt_frame  = {lane(val_in0, in0), lane(val_in1, in1), lane(val_in2, in2), lane(val_in3, in3)};
        pend_bytes = int'(val_in0) + int'(val_in1) + int'(val_in2) + int'(val_in3);
      end
    end
  end

  task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [3:0] v);
    in0 = a; in1 = b; in2 = c; in3 = d;
    {val_in0, val_in1, val_in2, val_in3} = v;
  endtask

  // Inputs change every cycle right after the edge; directed frames only at the sample cycles.
  task automatic run_edges(input int count, input bit directed);
    for (int e = 1; e <= count; e++) begin
      @(posedge clk_32f);
      #1;
      if (directed && e == 127)      set_in(8'h01, 8'h23, 8'h45, 8'h67, 4'b1111);
      else if (directed && e == 159) set_in(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b1010);
      else if (directed && e == 191) set_in(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
      else set_in(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
    end
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk_32f);
    #1;
    run++;
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0;
    set_in(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    release_reset();
    run_edges(400, 1'b1);
    reset_L = 1'b0;
    release_reset();
    run_edges(140, 1'b0);
    reset_L = 1'b0;
    release_reset();
    run_edges(300, 1'b0);
    @(negedge clk_32f);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
